// File: rtl/pipe_pkg.sv
// Shared MEM->WB payload layout (bit offsets/widths of each packed field) and sizing helpers.
package pipe_pkg;

  localparam int WORD_W    = 32;
  localparam int REG_W     = 5;
  localparam int EXC_W     = 5;
  localparam int MEMREAD_W = 3;

  // LSB offsets of each field inside the packed payload, instruction at bit 0.
  localparam int INSTR_B    = 0;
  localparam int EXC_B      = INSTR_B + WORD_W;
  localparam int OPC_B      = EXC_B + EXC_W;
  localparam int OVF_B      = OPC_B + WORD_W;
  localparam int RT_B       = OVF_B + 1;
  localparam int DEST_B     = RT_B + REG_W;
  localparam int ALU_B      = DEST_B + REG_W;
  localparam int MEMDATA_B  = ALU_B + WORD_W;
  localparam int MEMREAD_B  = MEMDATA_B + WORD_W;
  localparam int REGWRITE_B = MEMREAD_B + MEMREAD_W;
  localparam int MEMTOREG_B = REGWRITE_B + 1;

  localparam int WB_PAYLOAD_W = MEMTOREG_B + 1;

  // Pointer width for a DEPTH-entry buffer; a single entry still needs one bit.
  function automatic int PTR_W(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_pipe_mem.sv
// DEPTH x WIDTH storage for the WB stage: one synchronous write port, asynchronous read.
// Contents are not reset; validity is tracked by the controlling stage.
module wb_pipe_mem
  import pipe_pkg::*;
#(
  parameter int WIDTH = 105,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [PTR_W(DEPTH)-1:0]  wr_ptr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [PTR_W(DEPTH)-1:0]  rd_ptr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/wb_pipe_stage.sv
// MEM->WB valid/ready buffer of DEPTH entries carrying payload plus bubble flag; 1-cycle latency,
// in_ready depends only on registered count (no out_ready path). Optional WB_PIPE_STALL_CNT_EN adds stall_cnt.
module wb_pipe_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 104,
  parameter int                DEPTH      = 2,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_nop,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_nop,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef WB_PIPE_STALL_CNT_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int PW = PTR_W(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            push;
  logic            pop;
  logic [DATA_W:0] head;

  // Explicit wrap so non-power-of-two depths cycle correctly.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign occupancy = count;
  assign out_data  = out_valid ? head[DATA_W-1:0] : RESET_DATA;
  assign out_nop   = out_valid ? head[DATA_W] : 1'b1;

  wb_pipe_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_ptr  (wr_ptr),
    .wr_data ({in_nop, in_data}),
    .rd_ptr  (rd_ptr),
    .rd_data (head)
  );

  // Flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef WB_PIPE_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Randomized and directed bench for wb_pipe_stage against a queue-based model of the buffer.
module tb_wb_pipe_stage;

  localparam int DW    = 32;
  localparam int DEPTH = 3;
  localparam int OW    = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] RST_D = '0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_nop = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_nop;
  logic [DW-1:0] out_data;
  logic [OW-1:0] occupancy;
`ifdef WB_PIPE_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  wb_pipe_stage #(
    .DATA_W     (DW),
    .DEPTH      (DEPTH),
    .RESET_DATA (RST_D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_nop    (in_nop),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_nop   (out_nop),
    .occupancy (occupancy)
`ifdef WB_PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  logic [DW:0]   mq[$];
  int            m_stall = 0;
  logic [DW-1:0] got[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an ordered queue bounded by DEPTH.
  always @(posedge clk or negedge rst_n) begin
    int sz;
    if (!rst_n) begin
      mq.delete();
      m_stall = 0;
    end else if (flush) begin
      mq.delete();
      m_stall = 0;
    end else begin
      sz = mq.size();
      if (sz != 0 && !out_ready && m_stall < 65535) m_stall++;
      if (sz != 0 && out_ready) void'(mq.pop_front());
      if (in_valid && sz < DEPTH) mq.push_back({in_nop, in_data});
    end
  end

  always @(negedge clk) begin
    int sz;
    sz = mq.size();
    chk("out_valid", out_valid, sz != 0);
    chk("in_ready", in_ready, sz < DEPTH);
    chk("occupancy", occupancy, sz);
    chk("out_nop", out_nop, (sz != 0) ? mq[0][DW] : 1'b1);
    chk("out_data", out_data, (sz != 0) ? mq[0][DW-1:0] : RST_D);
`ifdef WB_PIPE_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    if (sz != 0 && out_ready && rst_n && !flush) got.push_back(out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [DW-1:0] d, input logic nop);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_nop   = nop;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int xseen;
    logic [DW-1:0] fill_exp[$];
    fill_exp = '{32'hA, 32'hB, 32'hC, 32'hD};

    // Reset / empty
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_nop", out_nop, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occupancy", occupancy, 0);
    rst_n = 1'b1;
    tick();

    // Single-entry latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h0000DEAD;
    in_nop    = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("lat_out_valid", out_valid, 1);
    chk("lat_out_data", out_data, 32'h0000DEAD);
    tick();
    chk("lat_occ_after", occupancy, 0);

    // Fill and backpressure
    out_ready = 1'b0;
    push_one(32'hA, 1'b0);
    push_one(32'hB, 1'b0);
    push_one(32'hC, 1'b0);
    chk("full_in_ready", in_ready, 0);
    chk("full_occ", occupancy, 3);
    in_valid = 1'b1;
    in_data  = 32'hD;
    repeat (3) tick();
    chk("full_hold_occ", occupancy, 3);
    got.delete();
    out_ready = 1'b1;
    push_one(32'hD, 1'b0);
    repeat (6) tick();
    chk("fill_cnt", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("fill_order", got[i], fill_exp[i]);

    // Wrap-around with toggling out_ready
    got.delete();
    fork
      begin
        for (int v = 1; v <= 10; v++) push_one(DW'(v), 1'b0);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          out_ready = (i % 2 == 0);
          tick();
        end
      end
    join
    out_ready = 1'b1;
    repeat (5) tick();
    chk("wrap_cnt", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++) chk("wrap_order", got[i], i + 1);

    // Flush priority over a same-cycle push
    out_ready = 1'b0;
    push_one(32'h11, 1'b0);
    push_one(32'h22, 1'b0);
    chk("pre_flush_occ", occupancy, 2);
    got.delete();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h5A5A5A5A;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_occ", occupancy, 0);
    chk("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (4) tick();
    xseen = 0;
    foreach (got[i]) if (got[i] == 32'h5A5A5A5A) xseen++;
    chk("flush_x_seen", xseen, 0);
    chk("flush_none_out", got.size(), 0);

    // Bubble held under stall
    flush = 1'b1;
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_nop    = 1'b1;
    in_data   = 32'h77;
    tick();
    in_valid = 1'b0;
    in_nop   = 1'b0;
    repeat (5) tick();
    chk("bubble_nop", out_nop, 1);
    chk("bubble_occ", occupancy, 1);
`ifdef WB_PIPE_STALL_CNT_EN
    chk("stall_cnt_5", stall_cnt, 5);
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("bubble_flushed_occ", occupancy, 0);
`ifdef WB_PIPE_STALL_CNT_EN
    chk("stall_cnt_clr", stall_cnt, 0);
`endif

    // Randomized traffic with occasional flush and mid-transfer reset
    for (int n = 0; n < 400; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      in_nop    = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 149) == 0) begin
        #2;
        rst_n = 1'b0;
      end
      tick();
      rst_n = 1'b1;
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
